// File: rtl/timer_io.sv
// timer_io: memory-mapped countdown timer for the processor bus.
// Register map (A): 0 LOAD/COUNT, 1 CTRL {auto,en}, 2 STATUS {done}, 3 reserved.
// A prescaler divides Clock by CLK_DIV into ticks; each tick decrements the
// count. Expiry sets a sticky done flag that software clears via STATUS.
// Read data is registered, so Q is valid one cycle after the request.
module timer_io #(
  parameter int CLK_DIV = 50000,
  parameter int PW      = 16
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        cs,
  input  logic        W,
  input  logic [1:0]  A,
  input  logic [15:0] D,
  output logic [15:0] Q,
  output logic        Done
);

  // Decoded bus request for one edge.
  typedef struct packed {
    logic wr_load;
    logic wr_ctrl;
    logic wr_stat;
    logic rd;
  } bus_req_t;

  localparam logic [PW-1:0] PMAX = PW'(CLK_DIV - 1);

  bus_req_t      req;
  logic [15:0]   load;
  logic [15:0]   count;
  logic [PW-1:0] pcount;
  logic          en;
  logic          auto;
  logic          done;
  logic          tick;
  logic          restart;
  logic          expire;
  logic [15:0]   rdata;

  // Bus decode: writes and reads only act while selected.
  always_comb begin
    req         = '0;
    req.wr_load = cs & W & (A == 2'd0);
    req.wr_ctrl = cs & W & (A == 2'd1);
    req.wr_stat = cs & W & (A == 2'd2);
    req.rd      = cs & ~W;
  end

  // Tick/expiry qualification. A LOAD write on the same edge swallows the
  // tick entirely: no decrement, no done set, no auto-disable.
  always_comb begin
    tick    = en & (pcount == PMAX);
    restart = req.wr_ctrl & D[0] & ~en;
    expire  = tick & ~req.wr_load & (count <= 16'd1);
  end

  // Prescaler: free-runs while enabled, re-phased by LOAD or a fresh enable.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                   pcount <= '0;
    else if (req.wr_load | restart) pcount <= '0;
    else if (en)                   pcount <= tick ? '0 : pcount + 1'b1;
  end

  // Reload value, written only through LOAD.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)          load <= '0;
    else if (req.wr_load) load <= D;
  end

  // Countdown: LOAD wins over a tick; never wraps below zero.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)          count <= '0;
    else if (req.wr_load) count <= D;
    else if (tick) begin
      if (count > 16'd1) count <= count - 16'd1;
      else if (auto)     count <= load;
      else               count <= '0;
    end
  end

  // Enable: a CTRL write always has the final say; otherwise a one-shot
  // expiry stops the timer.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)                 en <= 1'b0;
    else if (req.wr_ctrl)        en <= D[0];
    else if (expire & ~auto)     en <= 1'b0;
  end

  // Auto-reload mode bit.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)          auto <= 1'b0;
    else if (req.wr_ctrl) auto <= D[1];
  end

  // Sticky done: a setting expiry beats a simultaneous STATUS clear.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)          done <= 1'b0;
    else if (expire)      done <= 1'b1;
    else if (req.wr_stat) done <= 1'b0;
  end

  // Read mux from pre-edge state.
  always_comb begin
    rdata = '0;
    case (A)
      2'd0:    rdata = count;
      2'd1:    rdata = {14'b0, auto, en};
      2'd2:    rdata = {15'b0, done};
      default: rdata = '0;
    endcase
  end

  // Registered read data; holds when no read is requested.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)     Q <= '0;
    else if (req.rd) Q <= rdata;
  end

  assign Done = done;

endmodule

// File: tb/tb_timer_io.sv
// Bench for timer_io: directed scenarios plus a random bus phase, all
// compared against a rule-level reference model every cycle.
module tb_timer_io;

  localparam int DIV = 4;

  logic        Clock;
  logic        Resetn;
  logic        cs;
  logic        W;
  logic [1:0]  A;
  logic [15:0] D;
  logic [15:0] Q;
  logic        Done;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [15:0] m_load, m_count, m_q;
  logic        m_en, m_auto, m_done;
  int          m_ph;   // enabled cycles since last re-phase, modulo DIV

  timer_io #(.CLK_DIV(DIV), .PW(16)) dut (
    .Clock(Clock), .Resetn(Resetn), .cs(cs), .W(W), .A(A), .D(D),
    .Q(Q), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %b want %b", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_load = '0; m_count = '0; m_q = '0;
    m_en = 0; m_auto = 0; m_done = 0; m_ph = 0;
  endtask

  // One clock edge of the timer, from the behavioural rules.
  task automatic model_step(input logic c, input logic w, input logic [1:0] a,
                            input logic [15:0] d);
    logic tick, wl, wc, ws, expire, en0;
    tick = m_en && (m_ph == DIV - 1);
    wl = c && w && (a == 2'd0);
    wc = c && w && (a == 2'd1);
    ws = c && w && (a == 2'd2);
    en0 = m_en;
    if (c && !w) begin
      case (a)
        2'd0: m_q = m_count;
        2'd1: m_q = {14'b0, m_auto, m_en};
        2'd2: m_q = {15'b0, m_done};
        default: m_q = 16'h0;
      endcase
    end
    if (en0) m_ph = (m_ph + 1) % DIV;
    if (wl || (wc && d[0] && !en0)) m_ph = 0;
    expire = tick && !wl && (m_count <= 1);
    if (wl) begin
      m_load = d; m_count = d;
    end else if (tick) begin
      if (m_count > 1) m_count = m_count - 1;
      else if (m_auto) m_count = m_load;
      else begin m_count = 0; m_en = 0; end
    end
    if (expire) m_done = 1;
    else if (ws) m_done = 0;
    if (wc) begin m_en = d[0]; m_auto = d[1]; end
  endtask

  // Drive one bus cycle, step model at the edge, compare 1 time unit later.
  task automatic bus(input logic c, input logic w, input logic [1:0] a, input logic [15:0] d);
    cs = c; W = w; A = a; D = d;
    @(posedge Clock);
    model_step(c, w, a, d);
    #1;
    chk16("model_q", Q, m_q);
    chk1("model_done", Done, m_done);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(0, 0, 2'd0, 16'h0);
  endtask

  initial begin
    cs = 0; W = 0; A = 0; D = 0;
    Resetn = 0;
    model_reset();
    #12;
    chk16("reset_q", Q, 16'h0);
    chk1("reset_done", Done, 1'b0);
    Resetn = 1;

    // Reset state of all four registers
    for (int i = 0; i < 4; i++) begin
      bus(1, 0, 2'(i), 16'h0);
      chk16("rd_reset", Q, 16'h0);
    end
    chk1("rd_reset_done", Done, 1'b0);

    // LOAD while disabled: count does not move
    bus(1, 1, 2'd0, 16'h1234);
    bus(1, 0, 2'd0, 16'h0);
    chk16("load_rd", Q, 16'h1234);
    idle(10);
    bus(1, 0, 2'd0, 16'h0);
    chk16("load_hold", Q, 16'h1234);

    // One-shot: LOAD=3, enable at E
    bus(1, 1, 2'd0, 16'd3);
    bus(1, 1, 2'd1, 16'h0001);
    for (int k = 1; k <= 13; k++) begin
      bus(1, 0, 2'd0, 16'h0);
      if (k == 5)  chk16("os_cnt2", Q, 16'd2);
      if (k == 9)  chk16("os_cnt1", Q, 16'd1);
      if (k == 11) chk1("os_not_done", Done, 1'b0);
      if (k == 13) begin
        chk16("os_cnt0", Q, 16'd0);
        chk1("os_done", Done, 1'b1);
      end
    end
    bus(1, 0, 2'd1, 16'h0);
    chk16("os_ctrl", Q, 16'h0000);
    for (int i = 0; i < 50; i++) begin
      bus(0, 0, 2'd0, 16'h0);
      chk1("os_sticky", Done, 1'b1);
    end

    // Auto-reload: LOAD=2, CTRL=3 at E
    bus(1, 1, 2'd2, 16'hBEEF);
    chk1("clr_done", Done, 1'b0);
    bus(1, 1, 2'd0, 16'd2);
    bus(1, 1, 2'd1, 16'h0003);
    idle(7);
    chk1("ar_not_yet", Done, 1'b0);
    idle(1);                               // E+8
    chk1("ar_done", Done, 1'b1);
    bus(1, 0, 2'd0, 16'h0);                // E+9
    chk16("ar_reload", Q, 16'd2);
    bus(1, 1, 2'd2, 16'h0);                // E+10
    chk1("ar_clr", Done, 1'b0);
    bus(1, 0, 2'd1, 16'h0);                // E+11
    chk16("ar_ctrl", Q, 16'h0003);
    idle(4);                               // E+15
    chk1("ar_pre2", Done, 1'b0);
    idle(1);                               // E+16
    chk1("ar_done2", Done, 1'b1);

    // Collisions
    bus(1, 1, 2'd2, 16'h0);                // E+17
    chk1("col_clr", Done, 1'b0);
    idle(6);                               // E+23
    bus(1, 1, 2'd2, 16'h0);                // E+24: clear vs expire
    chk1("col_set_wins", Done, 1'b1);
    bus(1, 1, 2'd0, 16'd3);                // E+25
    idle(3);                               // E+28
    bus(1, 1, 2'd0, 16'd5);                // E+29: LOAD on tick
    bus(1, 0, 2'd0, 16'h0);
    chk16("col_load_wins", Q, 16'd5);
    bus(1, 1, 2'd1, 16'h0000);

    // Reset mid-count
    bus(1, 1, 2'd0, 16'h00FF);
    bus(1, 1, 2'd1, 16'h0001);
    idle(6);
    bus(1, 0, 2'd0, 16'h0);
    chk16("mid_q_nonzero", Q, 16'h00FE);
    cs = 0; W = 0;
    #1 Resetn = 0;
    model_reset();
    #2;
    chk16("mid_rst_q", Q, 16'h0);
    chk1("mid_rst_done", Done, 1'b0);
    #2 Resetn = 1;
    for (int i = 0; i < 20; i++) begin
      bus(1, 0, 2'd0, 16'h0);
      chk16("post_rst_cnt", Q, 16'h0);
    end

    // Random bus traffic against the model
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45)      bus(0, 1'($urandom), 2'($urandom_range(0, 3)), 16'($urandom));
      else if (r < 67) bus(1, 0, 2'($urandom_range(0, 3)), 16'($urandom));
      else if (r < 75) bus(1, 1, 2'd0, 16'($urandom_range(0, 6)));
      else if (r < 86) bus(1, 1, 2'd1, 16'($urandom_range(0, 3)));
      else if (r < 95) bus(1, 1, 2'd2, 16'($urandom));
      else             bus(1, 1, 2'd3, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_io.md
Name: timer_io

Overview:
- Memory-mapped countdown timer peripheral on the processor bus, at base ADDR[15:12] = 4'h2, beside the LED and switch ports.
- Consumes the processor's DOUT/ADDR/W like the LED register, and returns registered read data to the top-level DIN mux.
- Gives programs a hardware delay/tick source: the processor polls a sticky done flag.
- The Done level is also exported for direct LED display.

Parameters:
- CLK_DIV, 50000, clock cycles per timer tick (1 ms at 50 MHz); legal range 2..65535.
- PW, 16, prescaler counter width; must satisfy 2^PW >= CLK_DIV.

Ports:
- Clock  input  1  system clock, all state on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- cs  input  1  chip select, driven by top level as (ADDR[15:12] == 4'h2).
- W  input  1  processor write strobe.
- A  input  2  register offset, ADDR[1:0].
- D  input  16  write data, processor DOUT.
- Q  output  16  registered read data, to the DIN mux.
- Done  output  1  sticky done flag level.

Behaviour:
- Clock is Clock and reset is Resetn: one clock; reset is asynchronous and active-low.
- Register map: 0 = LOAD/COUNT, 1 = CTRL, 2 = STATUS, 3 = reserved (reads 0, writes ignored).
- Writes take effect at the rising edge when cs & W:
  - A=0: load <= D, count <= D, pcount <= 0; done unchanged.
  - A=1: en <= D[0], auto <= D[1]. pcount <= 0 on any CTRL write with D[0]=1 while en=0 (restart).
  - A=2: done <= 0, any data value.
- Reads: when cs & ~W at an edge, Q <= selected value, so Q is valid one cycle after the request (same latency as the instruction memory). Otherwise Q holds.
  - A=0 returns count.
  - A=1 returns {14'b0, auto, en}.
  - A=2 returns {15'b0, done}.
  - A=3 returns 0.
- Prescaler:
  - While en=1, pcount increments each cycle and wraps from CLK_DIV-1 to 0.
  - tick = en & (pcount == CLK_DIV-1).
  - While en=0, pcount holds.
- On tick:
  - count > 1: count <= count - 1.
  - count == 1: done <= 1. If auto=1, count <= load and en stays 1. Else count <= 0 and en <= 0.
  - count == 0: done <= 1, en <= 0 unless auto=1 (then count <= load).
- Done output = done register, combinational from the flop.
- Simultaneous events at one edge:
  - Write to LOAD and tick: the write wins; count <= D, no decrement, no done set.
  - STATUS clear and a done-setting tick: set wins, done = 1.
  - CTRL write of en=0 and tick: the tick is still processed (count/done update), then en = 0.
- Count wrap: never decrements below 0; no underflow to FFFF.
- Reset, including mid-count: load, count, pcount, en, auto, done and Q all clear to 0 immediately; after release the timer is idle until a CTRL write.
- cs=0: no state change from the bus, Q holds; the timer keeps running.

Test Plan (CLK_DIV=4 unless stated):
- Reset, then read all four offsets -> Q = 0x0000 each, one cycle after each request; Done = 0.
- Write LOAD=0x1234, read A=0 -> Q = 0x1234 on the cycle after the read; count unchanged while en=0.
- One-shot: LOAD=3, then CTRL=0x0001 at edge E -> count 2 at E+4 and 1 at E+8; at E+12 count = 0, Done = 1, CTRL reads 0x0000. Done stays 1 for 50 more cycles.
- Auto-reload: LOAD=2, CTRL=0x0003 at edge E -> Done = 1 at E+8 with count = 2 and en = 1. STATUS clear at E+10 -> Done = 0; Done = 1 again at E+16.
- Collisions: STATUS clear issued on the same edge as a done-setting tick -> Done = 1. LOAD=5 written on a tick edge with count=3 -> count = 5.
- Reset mid-count: LOAD=0x00FF, enable, assert Resetn low between edges -> all outputs 0 before the next edge. After release, count holds 0 for 20 cycles.
